data_mem_interface: RTL and testbench
=====================================

// Module: data_mem_interface
// PURPOSE
//  Load/store unit between the single-cycle datapath's data memory port and a 64-bit valid/ready memory bus.
//  Turns funct3 width codes into byte enables and lane-shifted write data, then realigns and sign/zero-extends load data.
//  Holds the datapath via stall until the bus transaction completes; a bus timeout guards against a hung bus.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in REQ+WAIT_R before abort; 0 disables the timeout counter
//  CNT_WIDTH       8    width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst             in   1   reset, asynchronous, active-low
//  req_read_en     in   1   load request (datapath data_mem_read_en)
//  req_write_en    in   1   store request (datapath data_mem_write_en)
//  req_addr        in   32  byte address (ALU result)
//  req_write_data  in   64  store data (rs2)
//  req_width       in   3   funct3: [1:0] 00=B 01=H 10=W 11=D; [2]=unsigned (loads only)
//  stall           out  1   1 = hold PC/regfile; datapath commits when 0
//  rdata           out  64  aligned, extended load result; valid when stall=0 in DONE
//  bus_err         out  1   1-cycle pulse: transaction aborted by timeout
//  misalign_err    out  1   1-cycle pulse: misaligned access (DMEM_MISALIGN_TRAP_EN only)
//  bad_addr        out  32  address of last misaligned access
//  bus_valid       out  1   request valid; held with stable fields until bus_ready
//  bus_ready       in   1   request accepted in a cycle where bus_valid=1
//  bus_we          out  1   1 = write
//  bus_addr        out  32  {req_addr[31:3],3'b000}
//  bus_be          out  8   byte enables
//  bus_wdata       out  64  lane-shifted store data
//  bus_rvalid      in   1   read data valid; earliest one cycle after the read handshake
//  bus_rdata       in   64  read data, full doubleword
// BEHAVIOUR
//  Reset: state=IDLE, counter=0; stall, bus_valid, bus_we, bus_err, misalign_err=0; rdata, bus_addr, bus_be, bus_wdata, bad_addr=0.
//  Reset mid-transaction aborts immediately; bus_valid drops asynchronously; the bus tolerates abandoned requests.
//  FSM IDLE->REQ->(WAIT_R if read)->DONE->IDLE; ERR only with the macro enabled.
//  IDLE: request = rd|wr; stall = request (combinational). On request, register bus fields and go to REQ.
//    rd&wr together: treated as a write.
//  REQ: bus_valid=1; on bus_ready go to WAIT_R (read) or DONE (write).
//  WAIT_R: on bus_rvalid, capture rdata and go to DONE.
//  DONE: stall=0 for exactly one cycle, rdata stable; the datapath commits at the edge; next state is IDLE.
//  Minimum latency, zero-wait bus: store = 3 cycles incl. DONE; load = 4 cycles.
//  size = 1<<req_width[1:0] bytes; lane = req_addr[2:0].
//  bus_be = ((1<<size)-1)<<lane, truncated to 8 bits; bus_wdata = req_write_data<<(8*lane).
//  rdata = bus_rdata>>(8*lane), keep size bytes; sign-extend if req_width[2]=0, else zero-extend.
//    Width 111 is decoded as LD.
//  Timeout: counter clears on entering REQ and increments in REQ/WAIT_R.
//    At TIMEOUT_CYCLES: go to DONE, rdata=0, bus_err=1 for the DONE cycle, bus_valid drops.
//  A late bus_rvalid arriving in IDLE is ignored.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined:
//    In IDLE, a request with lane%size!=0 issues no bus cycle; latch bad_addr=req_addr; go to ERR.
//    ERR: stall=0, misalign_err=1, rdata=0, write dropped; next state IDLE.
//  Undefined: lane low bits forced to alignment (lane &= ~(size-1)); misalign_err=0; bad_addr=0; no ERR state.
// TESTING
//  1 LD addr 0x100, zero-wait bus, rdata 0x8877665544332211 -> stall 1,1,1,0; rdata=0x8877665544332211.
//  2 SB addr 0x103, data 0xAB -> bus_addr 0x100, bus_be=8'h08, bus_wdata[31:24]=0xAB, bus_we=1.
//  3 LH addr 0x106 on rdata 0x80FF000000000000 -> rdata 0xFFFFFFFFFFFF80FF; LHU -> 0x00000000000080FF.
//  4 bus_ready low 300 cycles, TIMEOUT_CYCLES=255 -> DONE after 255 cycles, bus_err 1-cycle pulse, rdata=0.
//  5 LW addr 0x102 -> macro on: no bus_valid, misalign_err pulse, bad_addr=0x102; macro off: bus_be=8'h0F.
//  6 rst low while in WAIT_R -> bus_valid/stall 0 immediately; next LD after release completes normally.

Source files
------------

// File: rtl/data_mem_interface_if.sv
// +----------------------------------------------------------------------------+
// | data_mem_interface_if: 64-bit valid/ready data memory bus.                  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface data_mem_interface_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [31:0] addr;
  logic [7:0]  be;
  logic [63:0] wdata;
  logic        rvalid;
  logic [63:0] rdata;

  modport master (
    output valid, we, addr, be, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, be, wdata,
    output ready, rvalid, rdata
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_interface.sv
// +----------------------------------------------------------------------------+
// | data_mem_interface: load/store unit between datapath and 64-bit mem bus.    |
// | Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN. Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_mem_interface #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        req_read_en_i,
  input  wire logic        req_write_en_i,
  input  wire logic [31:0] req_addr_i,
  input  wire logic [63:0] req_write_data_i,
  input  wire logic [2:0]  req_width_i,
  output logic             stall_o,
  output logic [63:0]      rdata_o,
  output logic             bus_err_o,
  output logic             misalign_err_o,
  output logic [31:0]      bad_addr_o,
  data_mem_interface_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT_R = 3'd2,
    S_DONE   = 3'd3
`ifdef DMEM_MISALIGN_TRAP_EN
    , S_ERR  = 3'd4
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [7:0]  be_q;
  logic [63:0] wdata_q;
  logic [2:0]  lane_q;
  logic [2:0]  width_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic        w_request;
  logic        w_stall;
  logic        w_issue;
  logic        w_capture;
  logic        w_abort;
  logic        w_timeout_hit;
  logic [3:0]  w_size;
  logic [2:0]  w_lmask;
  logic [2:0]  w_lane_raw;
  logic [2:0]  w_lane;
  logic [7:0]  w_bemask;
  logic [63:0] w_shift;
  logic [63:0] w_load_ext;

  assign w_request  = req_read_en_i | req_write_en_i;
  assign w_size     = 4'd1 << req_width_i[1:0];
  assign w_lmask    = 3'(w_size - 4'd1);
  assign w_lane_raw = req_addr_i[2:0];
  assign w_bemask   = 8'((16'd1 << w_size) - 16'd1);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic        w_misaligned;
  logic        w_trap;
  logic [31:0] bad_addr_q;
  assign w_misaligned   = |(w_lane_raw & w_lmask);
  assign w_lane         = w_lane_raw;
  assign misalign_err_o = (state_q == S_ERR);
  assign bad_addr_o     = bad_addr_q;
`else
  // Without the trap, misaligned accesses silently round down to the natural boundary.
  assign w_lane         = w_lane_raw & ~w_lmask;
  assign misalign_err_o = 1'b0;
  assign bad_addr_o     = '0;
`endif

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      logic [CNT_WIDTH-1:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (w_issue) begin
          cnt_q <= '0;
        end else if ((state_q == S_REQ || state_q == S_WAIT_R) && cnt_q != '1) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      assign w_timeout_hit = ({{(32-CNT_WIDTH){1'b0}}, cnt_q} >= 32'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign w_timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    w_stall   = 1'b0;
    w_issue   = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    w_trap    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        w_stall = w_request;
        if (w_request) begin
`ifdef DMEM_MISALIGN_TRAP_EN
          if (w_misaligned) begin
            w_trap  = 1'b1;
            state_d = S_ERR;
          end else begin
            w_issue = 1'b1;
            state_d = S_REQ;
          end
`else
          w_issue = 1'b1;
          state_d = S_REQ;
`endif
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (bus.ready) begin
          state_d = we_q ? S_DONE : S_WAIT_R;
        end else if (w_timeout_hit) begin
          w_abort = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WAIT_R: begin
        w_stall = 1'b1;
        if (bus.rvalid) begin
          w_capture = 1'b1;
          state_d   = S_DONE;
        end else if (w_timeout_hit) begin
          w_abort = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
`ifdef DMEM_MISALIGN_TRAP_EN
      S_ERR: begin
        state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    w_shift = bus.rdata >> {lane_q, 3'b000};
    case (width_q[1:0])
      2'b00:   w_load_ext = width_q[2] ? {56'd0, w_shift[7:0]}
                                       : {{56{w_shift[7]}}, w_shift[7:0]};
      2'b01:   w_load_ext = width_q[2] ? {48'd0, w_shift[15:0]}
                                       : {{48{w_shift[15]}}, w_shift[15:0]};
      2'b10:   w_load_ext = width_q[2] ? {32'd0, w_shift[31:0]}
                                       : {{32{w_shift[31]}}, w_shift[31:0]};
      default: w_load_ext = w_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      lane_q  <= '0;
      width_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      bad_addr_q <= '0;
`endif
    end else begin
      err_q <= w_abort;
      if (w_issue) begin
        // Simultaneous read and write requests resolve to a write.
        we_q    <= req_write_en_i;
        addr_q  <= {req_addr_i[31:3], 3'b000};
        be_q    <= w_bemask << w_lane;
        wdata_q <= req_write_data_i << {w_lane, 3'b000};
        lane_q  <= w_lane;
        width_q <= req_width_i;
      end
      if (w_capture) begin
        rdata_q <= w_load_ext;
      end
      if (w_abort) begin
        rdata_q <= '0;
      end
`ifdef DMEM_MISALIGN_TRAP_EN
      if (w_trap) begin
        bad_addr_q <= req_addr_i;
        rdata_q    <= '0;
      end
`endif
    end
  end

  // bus.valid decodes straight from the state register so reset drops it at once.
  assign bus.valid = (state_q == S_REQ);
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.be    = be_q;
  assign bus.wdata = wdata_q;

  assign stall_o   = rst_n & w_stall;
  assign rdata_o   = rdata_q;
  assign bus_err_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_interface.sv
// +----------------------------------------------------------------------------+
// | tb_data_mem_interface: scoreboard bench for data_mem_interface.             |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_data_mem_interface;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    string       name;
  } bus_exp_t;

  typedef struct {
    logic [63:0] rdata;
    logic        chk_rdata;
    logic        err;
    logic        mis;
    string       name;
  } cmt_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [2:0]  width;
  logic        stall;
  logic [63:0] rdata;
  logic        bus_err;
  logic        mis_err;
  logic [31:0] bad_addr;

  logic        ready_en = 1'b1;
  logic        suppress_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  bus_exp_t bus_q[$];
  cmt_exp_t cmt_q[$];

  always #5 clk = ~clk;

  data_mem_interface_if bus ();

  data_mem_interface #(
    .TIMEOUT_CYCLES(255),
    .CNT_WIDTH     (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_read_en_i   (rd),
    .req_write_en_i  (wr),
    .req_addr_i      (addr),
    .req_write_data_i(wdata),
    .req_width_i     (width),
    .stall_o         (stall),
    .rdata_o         (rdata),
    .bus_err_o       (bus_err),
    .misalign_err_o  (mis_err),
    .bad_addr_o      (bad_addr),
    .bus             (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Bus slave: ready follows ready_en, read data returns one cycle after the handshake.
  initial begin : responder
    logic hs;
    bus.ready  = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    forever begin
      @(negedge clk);
      hs = bus.valid && bus.ready && !bus.we;
      @(posedge clk);
      #1;
      bus.rvalid = hs && !suppress_rvalid;
      bus.rdata  = hs ? mem_rdata : 64'd0;
      bus.ready  = ready_en;
    end
  end

  initial begin : monitor
    bus_exp_t be_e;
    cmt_exp_t ce;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.valid && bus.ready) begin
          checks++;
          if (bus_q.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected: got addr 0x%h we %0b, expected no request", bus.addr, bus.we);
          end else begin
            be_e = bus_q.pop_front();
            if (bus.we !== be_e.we || bus.addr !== be_e.addr || bus.be !== be_e.be || bus.wdata !== be_e.wdata) begin
              errors++;
              $display("FAIL %s: got we %0b addr 0x%h be 0x%h wdata 0x%h expected we %0b addr 0x%h be 0x%h wdata 0x%h",
                       be_e.name, bus.we, bus.addr, bus.be, bus.wdata, be_e.we, be_e.addr, be_e.be, be_e.wdata);
            end
          end
        end
        if ((rd || wr) && !stall) begin
          checks++;
          if (cmt_q.size() == 0) begin
            errors++;
            $display("FAIL commit_unexpected: got commit rdata 0x%h, expected none", rdata);
          end else begin
            ce = cmt_q.pop_front();
            if ((ce.chk_rdata && rdata !== ce.rdata) || bus_err !== ce.err || mis_err !== ce.mis) begin
              errors++;
              $display("FAIL %s: got rdata 0x%h err %0b mis %0b expected rdata 0x%h err %0b mis %0b",
                       ce.name, rdata, bus_err, mis_err, ce.rdata, ce.err, ce.mis);
            end
          end
        end
      end
    end
  end

  task automatic run_txn(input string name, input logic t_rd, input logic t_wr,
                         input logic [31:0] t_addr, input logic [63:0] t_wdata, input logic [2:0] t_width,
                         input logic [63:0] t_mem, input logic exp_bus, input logic [7:0] exp_be,
                         input logic [63:0] exp_wdata, input logic [63:0] exp_rdata,
                         input logic exp_err, input logic exp_mis, input int exp_stall);
    int  n;
    bit  done;
    if (exp_bus) bus_q.push_back('{we: t_wr, addr: {t_addr[31:3], 3'b000}, be: exp_be,
                                    wdata: exp_wdata, name: {name, "_bus"}});
    cmt_q.push_back('{rdata: exp_rdata, chk_rdata: t_rd && !t_wr, err: exp_err, mis: exp_mis,
                      name: {name, "_commit"}});
    mem_rdata = t_mem;
    @(posedge clk);
    #1;
    rd = t_rd; wr = t_wr; addr = t_addr; wdata = t_wdata; width = t_width;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (stall) n++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_complete: got no commit in 400 cycles, expected commit", name);
    end else begin
      check({name, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    end
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    check({name, "_pulse_end"}, {62'd0, bus_err, mis_err}, 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit done;
    rst_n = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; width = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_stall",    64'(stall),     64'd0);
    check("rst_valid",    64'(bus.valid), 64'd0);
    check("rst_we",       64'(bus.we),    64'd0);
    check("rst_bus_err",  64'(bus_err),   64'd0);
    check("rst_mis_err",  64'(mis_err),   64'd0);
    check("rst_rdata",    rdata,          64'd0);
    check("rst_bus_addr", 64'(bus.addr),  64'd0);
    check("rst_bus_be",   64'(bus.be),    64'd0);
    check("rst_wdata",    bus.wdata,      64'd0);
    check("rst_bad_addr", 64'(bad_addr),  64'd0);

    run_txn("ld_100",  1, 0, 32'h100, 64'd0, 3'b011, 64'h8877665544332211, 1, 8'hFF, 64'd0,
            64'h8877665544332211, 0, 0, 3);
    run_txn("sb_103",  0, 1, 32'h103, 64'hAB, 3'b000, 64'd0, 1, 8'h08, 64'h00000000AB000000,
            64'd0, 0, 0, 2);
    run_txn("lh_106",  1, 0, 32'h106, 64'd0, 3'b001, 64'h80FF000000000000, 1, 8'hC0, 64'd0,
            64'hFFFFFFFFFFFF80FF, 0, 0, 3);
    run_txn("lhu_106", 1, 0, 32'h106, 64'd0, 3'b101, 64'h80FF000000000000, 1, 8'hC0, 64'd0,
            64'h00000000000080FF, 0, 0, 3);
    run_txn("sd_108",  0, 1, 32'h108, 64'h0123456789ABCDEF, 3'b011, 64'd0, 1, 8'hFF,
            64'h0123456789ABCDEF, 64'd0, 0, 0, 2);
    run_txn("sw_10c",  0, 1, 32'h10C, 64'hDEADBEEF, 3'b010, 64'd0, 1, 8'hF0, 64'hDEADBEEF00000000,
            64'd0, 0, 0, 2);
    run_txn("lb_105",  1, 0, 32'h105, 64'd0, 3'b000, 64'h00009A0000000000, 1, 8'h20, 64'd0,
            64'hFFFFFFFFFFFFFF9A, 0, 0, 3);
    run_txn("lbu_105", 1, 0, 32'h105, 64'd0, 3'b100, 64'h00009A0000000000, 1, 8'h20, 64'd0,
            64'h000000000000009A, 0, 0, 3);
    run_txn("lw_104",  1, 0, 32'h104, 64'd0, 3'b010, 64'h8000000000000000, 1, 8'hF0, 64'd0,
            64'hFFFFFFFF80000000, 0, 0, 3);
    run_txn("lwu_104", 1, 0, 32'h104, 64'd0, 3'b110, 64'h8000000000000000, 1, 8'hF0, 64'd0,
            64'h0000000080000000, 0, 0, 3);
    run_txn("w111_100", 1, 0, 32'h100, 64'd0, 3'b111, 64'hFEDCBA9876543210, 1, 8'hFF, 64'd0,
            64'hFEDCBA9876543210, 0, 0, 3);
    run_txn("rdwr_100", 1, 1, 32'h100, 64'h55AA55AA, 3'b010, 64'd0, 1, 8'h0F, 64'h0000000055AA55AA,
            64'd0, 0, 0, 2);

`ifdef DMEM_MISALIGN_TRAP_EN
    run_txn("lw_102_trap", 1, 0, 32'h102, 64'd0, 3'b010, 64'h1122334455667788, 0, 8'h00, 64'd0,
            64'd0, 0, 1, 1);
    check("bad_addr_102", 64'(bad_addr), 64'h102);
    run_txn("sh_107_trap", 0, 1, 32'h107, 64'h1234, 3'b001, 64'd0, 0, 8'h00, 64'd0,
            64'd0, 0, 1, 1);
    check("bad_addr_107", 64'(bad_addr), 64'h107);
`else
    run_txn("lw_102_align", 1, 0, 32'h102, 64'd0, 3'b010, 64'h1122334455667788, 1, 8'h0F, 64'd0,
            64'h0000000055667788, 0, 0, 3);
    run_txn("sh_107_align", 0, 1, 32'h107, 64'h1234, 3'b001, 64'd0, 1, 8'hC0, 64'h1234000000000000,
            64'd0, 0, 0, 2);
    check("bad_addr_off", 64'(bad_addr), 64'd0);
`endif

    ready_en = 1'b0;
    run_txn("ld_timeout", 1, 0, 32'h110, 64'd0, 3'b011, 64'h1111111111111111, 0, 8'h00, 64'd0,
            64'd0, 1, 0, 256);
    ready_en = 1'b1;

    // Reset asserted while the load waits for read data.
    bus_q.push_back('{we: 1'b0, addr: 32'h100, be: 8'hFF, wdata: 64'd0, name: "rst_ld_bus"});
    mem_rdata = 64'h0F0F0F0F0F0F0F0F;
    suppress_rvalid = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b1; wr = 1'b0; addr = 32'h100; wdata = '0; width = 3'b011;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.valid && bus.ready) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rst_ld_handshake: got no handshake in 20 cycles, expected handshake");
    end
    @(posedge clk);
    #2;
    check("wait_r_stall", 64'(stall), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_stall", 64'(stall),     64'd0);
    check("rst_async_valid", 64'(bus.valid), 64'd0);
    rd = 1'b0;
    suppress_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_rdata", rdata, 64'd0);

    run_txn("ld_after_rst", 1, 0, 32'h108, 64'd0, 3'b011, 64'h0123456789ABCDEF, 1, 8'hFF, 64'd0,
            64'h0123456789ABCDEF, 0, 0, 3);

    repeat (3) @(negedge clk);
    check("bus_q_drained", 64'(bus_q.size()), 64'd0);
    check("cmt_q_drained", 64'(cmt_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
